// File: rtl/jtag_pkg.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// jtag_pkg
// Shared definitions for the IEEE 1149.1 TAP controller.
//   tap_state_t  : 4-bit state type with the standard TAP encoding.
//                  All 16 codes are used.
//   IS_IR_COLUMN : bitmask indexed by state code. A bit is set for
//                  SEL_IR and for every state below it in the IR column.
// ---------------------------------------------------------------------------
package jtag_pkg;

   typedef enum logic [3:0] {
      EX2_DR   = 4'h0,
      EX1_DR   = 4'h1,
      SH_DR    = 4'h2,
      PAUSE_DR = 4'h3,
      SEL_IR   = 4'h4,
      UPD_DR   = 4'h5,
      CAP_DR   = 4'h6,
      SEL_DR   = 4'h7,
      EX2_IR   = 4'h8,
      EX1_IR   = 4'h9,
      SH_IR    = 4'hA,
      PAUSE_IR = 4'hB,
      RTI      = 4'hC,
      UPD_IR   = 4'hD,
      CAP_IR   = 4'hE,
      TLR      = 4'hF
   } tap_state_t;

   // Set bits: 4, 8, 9, A, B, D, E.
   localparam logic [15:0] IS_IR_COLUMN = 16'h6F10;

endpackage

// File: rtl/jtag_tap_fsm.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// jtag_tap_fsm
// IEEE 1149.1 TAP controller. It is a Moore machine clocked by tck. Every
// output decodes from the state register alone. The scan-block "clocks"
// are enables qualified on tck and are never gated clocks.
// Ports:
//   tck            : sole clock. The state register updates on the rising edge.
//   reset          : synchronous, active-high. Has priority over tms.
//   tms            : test mode select, sampled on the rising edge of tck.
//   tap_reset      : high in TEST_LOGIC_RESET.
//   tap_select     : 1 = the IR path drives tdo, 0 = the DR path drives tdo.
//   tap_enable     : tdo buffer enable. High while shifting.
//   tap_clock_ir/dr, tap_capture_ir/dr, tap_shift_ir/dr, tap_update_ir/dr :
//                    per-path scan-block enables.
//   tap_state      : current state code, for debug.
// ---------------------------------------------------------------------------
module jtag_tap_fsm
   import jtag_pkg::*;
(
   input  logic       tck,
   input  logic       reset,
   input  logic       tms,
   output logic       tap_reset,
   output logic       tap_select,
   output logic       tap_enable,
   output logic       tap_clock_ir,
   output logic       tap_capture_ir,
   output logic       tap_shift_ir,
   output logic       tap_update_ir,
   output logic       tap_clock_dr,
   output logic       tap_capture_dr,
   output logic       tap_shift_dr,
   output logic       tap_update_dr,
   output logic [3:0] tap_state
);

   tap_state_t state_reg;
   tap_state_t state_next;

   // Reset wins over tms. A scan that reset aborts therefore goes straight
   // to TLR and never passes through UPD_x.
   always_ff @(posedge tck) begin
      if (reset) begin
         state_reg <= TLR;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = TLR;
      unique case (state_reg)
         TLR:      state_next = tms ? TLR      : RTI;
         RTI:      state_next = tms ? SEL_DR   : RTI;
         SEL_DR:   state_next = tms ? SEL_IR   : CAP_DR;
         CAP_DR:   state_next = tms ? EX1_DR   : SH_DR;
         SH_DR:    state_next = tms ? EX1_DR   : SH_DR;
         EX1_DR:   state_next = tms ? UPD_DR   : PAUSE_DR;
         PAUSE_DR: state_next = tms ? EX2_DR   : PAUSE_DR;
         EX2_DR:   state_next = tms ? UPD_DR   : SH_DR;
         UPD_DR:   state_next = tms ? SEL_DR   : RTI;
         SEL_IR:   state_next = tms ? TLR      : CAP_IR;
         CAP_IR:   state_next = tms ? EX1_IR   : SH_IR;
         SH_IR:    state_next = tms ? EX1_IR   : SH_IR;
         EX1_IR:   state_next = tms ? UPD_IR   : PAUSE_IR;
         PAUSE_IR: state_next = tms ? EX2_IR   : PAUSE_IR;
         EX2_IR:   state_next = tms ? UPD_IR   : SH_IR;
         UPD_IR:   state_next = tms ? SEL_DR   : RTI;
         // All 16 codes are listed above. This branch is a safety net only.
         default:  state_next = TLR;
      endcase
   end

   // Output decode. No tms term appears here, so each enable is valid for
   // exactly the cycles spent in its state.
   always_comb begin
      tap_reset      = (state_reg == TLR);
      tap_select     = (state_reg == TLR) || IS_IR_COLUMN[state_reg];
      tap_capture_ir = (state_reg == CAP_IR);
      tap_shift_ir   = (state_reg == SH_IR);
      tap_update_ir  = (state_reg == UPD_IR);
      tap_clock_ir   = tap_capture_ir || tap_shift_ir;
      tap_capture_dr = (state_reg == CAP_DR);
      tap_shift_dr   = (state_reg == SH_DR);
      tap_update_dr  = (state_reg == UPD_DR);
      tap_clock_dr   = tap_capture_dr || tap_shift_dr;
      tap_enable     = tap_shift_ir || tap_shift_dr;
   end

   assign tap_state = state_reg;

endmodule

// File: doc/jtag_tap_fsm.md
Name: jtag_tap_fsm

Overview:
IEEE 1149.1 TAP controller for the JTAG scan top. Sequences the IR and DR scan paths from tms, clocked by tck. Drives the reset, select, tdo-enable and the capture/shift/update/clock enables for both scan blocks. Single-clock design: all scan-block "clocks" are clock enables qualified on tck, never gated clocks.

Parameters:
none; state encoding and width are fixed in the shared package.

Ports:
tck  input  1  sole clock; state register updates on rising edge
reset  input  1  synchronous, active-high; forces TEST_LOGIC_RESET on the next tck rising edge
tms  input  1  test mode select, sampled on rising tck
tap_reset  output  1  high while in TEST_LOGIC_RESET
tap_select  output  1  1 = IR path drives tdo, 0 = DR path
tap_enable  output  1  tdo buffer enable
tap_clock_ir  output  1  IR scan-block clock enable
tap_capture_ir  output  1  IR parallel-load enable
tap_shift_ir  output  1  IR shift enable
tap_update_ir  output  1  IR shadow-latch update enable
tap_clock_dr  output  1  DR scan-block clock enable
tap_capture_dr  output  1  DR parallel-load enable
tap_shift_dr  output  1  DR shift enable
tap_update_dr  output  1  DR shadow-latch update enable
tap_state  output  4  current state, for debug and bench observation

Behaviour:
- Clocking and reset: one clock (tck); reset is synchronous and active-high. reset has priority over tms.
- State after reset: TEST_LOGIC_RESET (4'hF). Outputs after reset: tap_reset=1, tap_select=1, all other outputs 0.
- Moore machine: all outputs decode combinationally from the state register only, with no tms term. Each enable is valid for exactly the cycles spent in its state.
- Transitions, written as state: next if tms=0 / next if tms=1:
  - TLR: RTI / TLR
  - RTI: RTI / SEL_DR
  - SEL_DR: CAP_DR / SEL_IR
  - CAP_DR: SH_DR / EX1_DR
  - SH_DR: SH_DR / EX1_DR
  - EX1_DR: PAUSE_DR / UPD_DR
  - PAUSE_DR: PAUSE_DR / EX2_DR
  - EX2_DR: SH_DR / UPD_DR
  - UPD_DR: RTI / SEL_DR
  - SEL_IR: CAP_IR / TLR
  - The IR column (CAP_IR..UPD_IR) mirrors the DR column. UPD_IR goes to RTI on tms=0 and SEL_DR on tms=1.
- Encoding: TLR=F, RTI=C, SEL_DR=7, CAP_DR=6, SH_DR=2, EX1_DR=1, PAUSE_DR=3, EX2_DR=0, UPD_DR=5, SEL_IR=4, CAP_IR=E, SH_IR=A, EX1_IR=9, PAUSE_IR=B, EX2_IR=8, UPD_IR=D.
- Output decode:
  - tap_capture_x: high in CAP_x.
  - tap_shift_x: high in SH_x.
  - tap_update_x: high in UPD_x, a one-cycle pulse per pass.
  - tap_clock_x: high in CAP_x or SH_x.
  - tap_enable: high in SH_IR or SH_DR.
  - tap_select: high in TLR and in every state from SEL_IR through UPD_IR, low elsewhere.
- Five consecutive tms=1 samples reach TLR from any state. No counter is used; this is a property of the graph and is verified, not implemented.
- Reset mid-shift: the next state is TLR. No update pulse is issued for the aborted scan.
- Illegal codes cannot occur, since all 16 codes are used. The next-state decode still carries a default branch to TLR.

Decomposition:
- Package jtag_pkg: tap_state_t, a 4-bit enum carrying the encoding above, plus the IS_IR_COLUMN helper constant set.
- No sub-module. The block is one next-state always and one state register, plus output decode.

Test Plan:
- Assert reset for 1 cycle with tms=X -> tap_state=F, tap_reset=1, tap_select=1, all enables 0.
- From TLR, tms sequence 0,1,0,0 -> states C,7,6,2. tap_capture_dr=1 in the CAP_DR cycle only. tap_shift_dr=1, tap_enable=1, tap_select=0 in SH_DR.
- From SH_DR, shift 8 cycles (tms=0) then tms 1,1 -> 8+1 cycles of shift_dr=1 including entry, then EX1_DR, UPD_DR. tap_update_dr=1 for exactly 1 cycle, then RTI on tms=0.
- From RTI, tms 1,1,0,0 -> SEL_DR, SEL_IR, CAP_IR (E), SH_IR (A). tap_select=1, tap_shift_ir=1, tap_clock_ir=1. Then tms 1,0,1,0 -> EX1_IR, PAUSE_IR, EX2_IR, SH_IR, with shift_ir=0 while paused.
- From each of the 16 states, apply tms=1 five times -> tap_state=F, with no intermediate tap_update_* pulse unless the path crosses UPD_x.
- In SH_DR, assert reset with tms=0 -> next state F. tap_update_dr never asserts. tap_enable drops the same cycle.
